// File: rtl/mcu_8bit_pkg.sv
// Shared definitions for the 8-bit MCU: opcodes, controller states, ALU
// function selects and the opcode-to-class decode used by the controller.
package mcu_8bit_pkg;

  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_LDA  = 4'h1;
  localparam logic [3:0] c_OP_STA  = 4'h2;
  localparam logic [3:0] c_OP_ADD  = 4'h3;
  localparam logic [3:0] c_OP_SUB  = 4'h4;
  localparam logic [3:0] c_OP_AND  = 4'h5;
  localparam logic [3:0] c_OP_OR   = 4'h6;
  localparam logic [3:0] c_OP_XOR  = 4'h7;
  localparam logic [3:0] c_OP_NOT  = 4'h8;
  localparam logic [3:0] c_OP_MOVR = 4'h9;
  localparam logic [3:0] c_OP_JMP  = 4'hA;
  localparam logic [3:0] c_OP_JZ   = 4'hB;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  // ALU selects share the opcode numbering; 0 passes the memory operand through.
  localparam logic [3:0] c_ALU_PASS = 4'h0;

  typedef enum logic [2:0] {
    s_RESET     = 3'd0,
    s_FETCH     = 3'd1,
    s_DECODE    = 3'd2,
    s_EXECUTE   = 3'd3,
    s_MEM       = 3'd4,
    s_WRITEBACK = 3'd5,
    s_HALT      = 3'd6,
    s_PAUSE     = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_MOVR, CLS_JMP, CLS_JZ, CLS_LOAD, CLS_STORE, CLS_HALT
  } op_class_t;

  function automatic op_class_t op_class(input logic [3:0] op);
    case (op)
      c_OP_LDA:                     op_class = CLS_LOAD;
      c_OP_STA:                     op_class = CLS_STORE;
      c_OP_ADD, c_OP_SUB, c_OP_AND,
      c_OP_OR, c_OP_XOR, c_OP_NOT:  op_class = CLS_ALU;
      c_OP_MOVR:                    op_class = CLS_MOVR;
      c_OP_JMP:                     op_class = CLS_JMP;
      c_OP_JZ:                      op_class = CLS_JZ;
      c_OP_HALT:                    op_class = CLS_HALT;
      default:                      op_class = CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mcu_8bit_ctrl_fsm.sv
// Instruction-cycle controller for the 8-bit MCU with retired-instruction counter.
// Optional single-step support (S_PAUSE, i_step_mode/i_step) under MCU_CTRL_STEP_EN.
module mcu_8bit_ctrl_fsm
  import mcu_8bit_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                resetPC,
  input  logic [3:0]          i_opcode,
  input  logic                i_zero_flag,
  input  logic                i_mem_ready,
`ifdef MCU_CTRL_STEP_EN
  input  logic                i_step_mode,
  input  logic                i_step,
`endif
  output logic                o_pc_reset,
  output logic                o_pc_inc,
  output logic                o_pc_load,
  output logic                o_ir_load,
  output logic                o_acc_load,
  output logic                o_reg_wr,
  output logic                o_mem_rd,
  output logic                o_mem_wr,
  output logic [3:0]          o_alu_op,
  output logic [2:0]          o_state,
  output logic                o_halted,
  output logic [RETIRE_W-1:0] o_retired_count
);

  state_t              state, state_nxt;
  logic [3:0]          op;
  logic                retire;
  logic [RETIRE_W-1:0] count;
  op_class_t           cls;
  state_t              after_retire;

  assign cls = op_class(op);

`ifdef MCU_CTRL_STEP_EN
  assign after_retire = i_step_mode ? s_PAUSE : s_FETCH;
`else
  assign after_retire = s_FETCH;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= s_RESET;
      count <= '0;
    end else if (resetPC) begin
      // An in-flight instruction is abandoned and never counted.
      state <= s_RESET;
    end else begin
      state <= state_nxt;
      if (retire) count <= count + RETIRE_W'(1);
    end
  end

  // Opcode is held from DECODE so EXECUTE/MEM/WRITEBACK see a stable value.
  always_ff @(posedge Clk) begin
    if (Reset)                 op <= c_OP_NOP;
    else if (state == s_DECODE) op <= i_opcode;
  end

  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    o_pc_reset = 1'b0;
    o_pc_inc   = 1'b0;
    o_pc_load  = 1'b0;
    o_ir_load  = 1'b0;
    o_acc_load = 1'b0;
    o_reg_wr   = 1'b0;
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_alu_op   = c_ALU_PASS;
    o_halted   = 1'b0;
    case (state)
      s_RESET: begin
        o_pc_reset = 1'b1;
        state_nxt  = s_FETCH;
      end
      s_FETCH: begin
        o_mem_rd = 1'b1;
        if (i_mem_ready) begin
          o_ir_load = 1'b1;
          o_pc_inc  = 1'b1;
          state_nxt = s_DECODE;
        end
      end
      s_DECODE: state_nxt = s_EXECUTE;
      s_EXECUTE: begin
        retire    = 1'b1;
        state_nxt = after_retire;
        case (cls)
          CLS_ALU: begin
            o_alu_op   = op;
            o_acc_load = 1'b1;
          end
          CLS_MOVR:  o_reg_wr  = 1'b1;
          CLS_JMP:   o_pc_load = 1'b1;
          CLS_JZ:    o_pc_load = i_zero_flag;
          CLS_LOAD, CLS_STORE: begin
            retire    = 1'b0;
            state_nxt = s_MEM;
          end
          CLS_HALT:  state_nxt = s_HALT;
          default:   ;
        endcase
      end
      s_MEM: begin
        if (cls == CLS_LOAD) o_mem_rd = 1'b1;
        else                 o_mem_wr = 1'b1;
        if (i_mem_ready) begin
          if (cls == CLS_LOAD) begin
            state_nxt = s_WRITEBACK;
          end else begin
            retire    = 1'b1;
            state_nxt = after_retire;
          end
        end
      end
      s_WRITEBACK: begin
        o_acc_load = 1'b1;
        retire     = 1'b1;
        state_nxt  = after_retire;
      end
      s_HALT: o_halted = 1'b1;
`ifdef MCU_CTRL_STEP_EN
      s_PAUSE: if (i_step) state_nxt = s_FETCH;
`endif
      default: state_nxt = s_RESET;
    endcase
  end

  assign o_state         = state;
  assign o_retired_count = count;

endmodule

// File: tb/tb_mcu_8bit_ctrl_fsm.sv
// Self-checking bench for mcu_8bit_ctrl_fsm: directed scenarios plus random
// instruction streams scored against a per-instruction cycle/strobe model.
module tb_mcu_8bit_ctrl_fsm;
  localparam int RW = 4;

  logic          Clk = 1'b0;
  logic          Reset, resetPC;
  logic [3:0]    i_opcode;
  logic          i_zero_flag, i_mem_ready;
  logic          o_pc_reset, o_pc_inc, o_pc_load, o_ir_load, o_acc_load;
  logic          o_reg_wr, o_mem_rd, o_mem_wr, o_halted;
  logic [3:0]    o_alu_op;
  logic [2:0]    o_state;
  logic [RW-1:0] o_retired_count;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  mcu_8bit_ctrl_fsm #(.RETIRE_W(RW)) dut (
    .Clk(Clk), .Reset(Reset), .resetPC(resetPC), .i_opcode(i_opcode),
    .i_zero_flag(i_zero_flag), .i_mem_ready(i_mem_ready),
    .o_pc_reset(o_pc_reset), .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load),
    .o_ir_load(o_ir_load), .o_acc_load(o_acc_load), .o_reg_wr(o_reg_wr),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_alu_op(o_alu_op),
    .o_state(o_state), .o_halted(o_halted), .o_retired_count(o_retired_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled around the falling edge.
  task automatic tick();
    @(negedge Clk);
  endtask

  // Runs one instruction starting in FETCH; fw/mw are ready-low cycles in FETCH/MEM.
  task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
    int  ld, st, alu, n;
    int  t_ir, t_inc, t_rd, t_wr, t_acc, t_reg, t_pld, t_prst, alu_seen;
    ld  = (op == 4'h1);
    st  = (op == 4'h2);
    alu = (op >= 4'h3 && op <= 4'h8);
    n   = fw + 3 + ((ld || st) ? mw + 1 : 0) + ld;
    t_ir = 0; t_inc = 0; t_rd = 0; t_wr = 0; t_acc = 0; t_reg = 0;
    t_pld = 0; t_prst = 0; alu_seen = -1;
    for (int c = 0; c < n; c++) begin
      i_opcode    = op;
      i_zero_flag = z;
      i_mem_ready = 1'b1;
      if (c < fw) i_mem_ready = 1'b0;
      if ((ld || st) && c >= fw + 3 && c < fw + 3 + mw) i_mem_ready = 1'b0;
      #1;
      if (c == 0) chk("start_fetch", int'(o_state), 1);
      t_ir += int'(o_ir_load);  t_inc += int'(o_pc_inc);
      t_rd += int'(o_mem_rd);   t_wr  += int'(o_mem_wr);
      t_acc += int'(o_acc_load); t_reg += int'(o_reg_wr);
      t_pld += int'(o_pc_load); t_prst += int'(o_pc_reset);
      if (o_acc_load) alu_seen = int'(o_alu_op);
      tick();
    end
    #1;
    exp_cnt = (exp_cnt + 1) % (1 << RW);
    chk($sformatf("op%0h_end_state", op), int'(o_state), (op == 4'hF) ? 6 : 1);
    chk($sformatf("op%0h_ir_load", op), t_ir, 1);
    chk($sformatf("op%0h_pc_inc", op), t_inc, 1);
    chk($sformatf("op%0h_mem_rd", op), t_rd, fw + 1 + (ld ? mw + 1 : 0));
    chk($sformatf("op%0h_mem_wr", op), t_wr, st ? mw + 1 : 0);
    chk($sformatf("op%0h_acc_load", op), t_acc, (alu || ld) ? 1 : 0);
    chk($sformatf("op%0h_reg_wr", op), t_reg, (op == 4'h9) ? 1 : 0);
    chk($sformatf("op%0h_pc_load", op), t_pld, (op == 4'hA) ? 1 : (op == 4'hB) ? int'(z) : 0);
    chk($sformatf("op%0h_pc_reset", op), t_prst, 0);
    if (alu || ld) chk($sformatf("op%0h_alu_op", op), alu_seen, alu ? int'(op) : 0);
    chk($sformatf("op%0h_count", op), int'(o_retired_count), exp_cnt);
    chk($sformatf("op%0h_halted", op), int'(o_halted), (op == 4'hF) ? 1 : 0);
  endtask

  initial begin
    Reset = 1'b1; resetPC = 1'b0; i_opcode = 4'h0; i_zero_flag = 1'b0; i_mem_ready = 1'b1;
    tick();
    // Reset held: S_RESET, only pc_reset asserted, counter clear
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rst_state", int'(o_state), 0);
      chk("rst_pc_reset", int'(o_pc_reset), 1);
      chk("rst_others", int'({o_pc_inc, o_pc_load, o_ir_load, o_acc_load, o_reg_wr,
                              o_mem_rd, o_mem_wr, o_halted, o_alu_op}), 0);
      chk("rst_count", int'(o_retired_count), 0);
    end
    Reset = 1'b0;
    tick(); #1;
    chk("first_fetch", int'(o_state), 1);
    chk("fetch_no_pc_reset", int'(o_pc_reset), 0);

    run_instr(4'h3, 1'b0, 0, 0);      // ADD
    run_instr(4'h1, 1'b0, 0, 2);      // LDA, 2 wait cycles in MEM
    run_instr(4'hB, 1'b0, 0, 0);      // JZ not taken
    run_instr(4'hB, 1'b1, 0, 0);      // JZ taken
    run_instr(4'h2, 1'b0, 1, 1);      // STA with waits

    // Random stream; narrow counter wraps several times
    for (int k = 0; k < 60; k++)
      run_instr(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2));

    // STA aborted mid-MEM by resetPC
    i_opcode = 4'h2; i_mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    i_mem_ready = 1'b0; #1;
    chk("abort_in_mem", int'(o_state), 4);
    chk("abort_mem_wr", int'(o_mem_wr), 1);
    resetPC = 1'b1;
    tick(); #1;
    chk("abort_state", int'(o_state), 0);
    chk("abort_mem_wr_drop", int'(o_mem_wr), 0);
    chk("abort_count", int'(o_retired_count), exp_cnt);
    resetPC = 1'b0; i_mem_ready = 1'b1;
    tick(); #1;
    chk("abort_refetch", int'(o_state), 1);

    // HALT parks; resetPC restarts with count kept
    run_instr(4'hF, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      chk("halt_park", int'({o_halted, o_mem_rd, o_ir_load, o_acc_load}), 8);
    end
    resetPC = 1'b1;
    tick(); #1;
    chk("halt_rpc_state", int'(o_state), 0);
    chk("halt_rpc_count", int'(o_retired_count), exp_cnt);
    resetPC = 1'b0;
    tick(); #1;
    chk("halt_rpc_fetch", int'(o_state), 1);

    // Reset wins over resetPC and clears the counter
    run_instr(4'h9, 1'b0, 0, 0);
    Reset = 1'b1; resetPC = 1'b1;
    tick(); #1;
    chk("prio_state", int'(o_state), 0);
    chk("prio_count", int'(o_retired_count), 0);
    exp_cnt = 0;
    Reset = 1'b0; resetPC = 1'b0;
    tick(); #1;
    chk("prio_fetch", int'(o_state), 1);
    run_instr(4'h7, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mcu_8bit_ctrl_fsm.md
# mcu_8bit_ctrl_fsm

Instruction-cycle controller for the 8-bit MCU core. It sequences fetch, decode, execute, memory and writeback for every instruction and drives the datapath strobes: PC, IR, accumulator, register file, ALU and memory. It sits between the top-level `Clk`/`Reset`/`resetPC` pins and the datapath, replacing ad-hoc enables with one state machine. It also keeps a retired-instruction counter for debug.

## Interface
- `RETIRE_W`, 16: width of retired-instruction counter.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high; full controller reset.
- `resetPC`  in  1  synchronous, active-high; restarts execution from PC 0; does not clear counter.
- `i_opcode`  in  4  IR[7:4], valid from DECODE onward.
- `i_zero_flag`  in  1  accumulator-zero flag from datapath.
- `i_mem_ready`  in  1  memory handshake; transfer completes on a cycle with request and ready both high.
- `o_pc_reset`, `o_pc_inc`, `o_pc_load`  out  1 each  PC controls.
- `o_ir_load`  out  1  IR capture.
- `o_acc_load`  out  1  accumulator capture.
- `o_reg_wr`  out  1  register-file write (acc -> reg[IR[3:0]]).
- `o_mem_rd`, `o_mem_wr`  out  1 each  memory requests.
- `o_alu_op`  out  4  ALU function select.
- `o_state`  out  3  current state encoding.
- `o_halted`  out  1  high in S_HALT.
- `o_retired_count`  out  RETIRE_W  instructions retired; wraps.

## Operation
- States: S_RESET=0, S_FETCH=1, S_DECODE=2, S_EXECUTE=3, S_MEM=4, S_WRITEBACK=5, S_HALT=6 (7 = S_PAUSE, step build only).
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 MOVR, A JMP, B JZ, F HALT. C/D/E decode as NOP.
- S_RESET: `o_pc_reset`=1, then go to FETCH.
- S_FETCH: `o_mem_rd`=1. While ready is low, stay. When ready: `o_ir_load`=1 and `o_pc_inc`=1 in the same cycle, then go to DECODE.
- S_DECODE: no strobes; the opcode is latched internally; always go to EXECUTE.
- S_EXECUTE actions by opcode:
  - ADD..NOT: `o_alu_op`=opcode, `o_acc_load`=1, go to FETCH.
  - MOVR: `o_reg_wr`=1, go to FETCH.
  - JMP: `o_pc_load`=1, go to FETCH.
  - JZ: `o_pc_load`=`i_zero_flag`, go to FETCH.
  - LDA, STA: go to MEM.
  - HALT: go to HALT.
  - NOP: go to FETCH.
- S_MEM: LDA drives `o_mem_rd`=1, STA drives `o_mem_wr`=1; hold until ready. On ready, LDA goes to WRITEBACK and STA goes to FETCH.
- S_WRITEBACK: `o_acc_load`=1, `o_alu_op`=0 (pass), go to FETCH.
- S_HALT: all strobes 0, `o_halted`=1. Leave only via `Reset` or `resetPC`.
- `o_alu_op`=0 in every state and case not listed above.
- Retire: counter +1 on the edge leaving the final state of an instruction (EXECUTE to FETCH/HALT, MEM to FETCH for STA, WRITEBACK). Wraps 2^RETIRE_W-1 -> 0.

## Timing
- Outputs are combinational decodes of the registered state. Gating by `i_mem_ready`/`i_zero_flag` is same-cycle (Mealy).
- Cycles with ready tied high:
  - ALU/MOVR/JMP/JZ/NOP: 3 (F,D,E).
  - STA: 4.
  - LDA: 5.
  - HALT: 3, then parked.
- Each low-ready cycle adds 1 cycle in FETCH or MEM.
- `Reset` high: next edge gives state=S_RESET and counter=0. While in S_RESET, every output except `o_pc_reset` is 0.
- `Reset` has priority over `resetPC`.
- `resetPC` high: next edge gives state=S_RESET; counter is kept. This applies from any state, including mid-MEM: the pending memory request drops, and that instruction is not retired.
- Holding `Reset`/`resetPC` high keeps the controller in S_RESET with `o_pc_reset`=1. The first FETCH comes one cycle after release.

## Configuration
- Macro `MCU_CTRL_STEP_EN`.
- With the macro defined, ports `i_step_mode` (in 1) and `i_step` (in 1) are added.
  - When `i_step_mode`=1, each retire goes to S_PAUSE instead of FETCH (HALT still goes to S_HALT).
  - S_PAUSE drives no strobes and goes to FETCH on the first cycle with `i_step`=1.
  - `Reset`/`resetPC` override S_PAUSE.
- Without the macro: the ports and S_PAUSE are absent, and the controller free-runs.

## Structure
- Shared package `mcu_8bit_pkg`:
  - opcode constants (`c_OP_*`);
  - state constants (`s_*`, 3-bit);
  - ALU op constants.
- The retired counter and the datapath both use this package.
- Single module, no sub-module.
- The opcode-to-class decode is a function in the package.

## Test plan
- Reset held 3 cycles, then released, ready=1: state goes 0 -> 1 one cycle after release; `o_pc_reset`=1 only in S_RESET; count=0.
- ADD (0x3): 3 cycles. `o_ir_load`/`o_pc_inc` in FETCH; in EXECUTE `o_alu_op`=3 and `o_acc_load`=1; count increments to 1.
- LDA with ready low 2 cycles in MEM: 7 cycles total; `o_mem_rd` held 3 cycles in MEM; `o_acc_load` in WRITEBACK.
- JZ with zero=0, then zero=1: `o_pc_load` is 0, then 1, in EXECUTE.
- HALT, then resetPC pulse: `o_halted`=1 after 3 cycles and persists for 20 cycles; resetPC returns the controller to S_RESET with count unchanged.
- STA in MEM with ready=0 and resetPC asserted: `o_mem_wr` drops the next cycle, state=S_RESET, and the count does not increment.
